// File: rtl/wiener_block_feeder.sv
// -----------------------------------------------------------------------------
// wiener_block_feeder
//
// Upstream producer for the Wiener filter stage. Pixels of one channel arrive
// in raster order and are collected into blocks of TOTAL_SAMPLES pixels. The
// block's mean and variance are computed as it fills. The block is then
// announced with a one-cycle stats_ready pulse and replayed on data_out, one
// pixel per cycle.
//
// The two-bank ping-pong buffer lets block N+1 be ingested while block N is
// replayed.
//
// Optional feature macro: MEAN_ROUND_EN
//   defined   : mean = (sum + TS/2) >> L (round half up); variance clamps at 0
//   undefined : truncating mean (variance cannot go negative)
//
// Ports
//   clk                clock
//   rst_n              synchronous active-low reset
//   pix_in             incoming pixel
//   pix_valid          pix_in valid
//   pix_ready          feeder can accept a pixel this cycle
//   blocks_per_frame   blocks per frame, sampled when a frame's first block is
//                      announced (0 behaves as 1)
//   stats_ready        one-cycle pulse: mean/variance valid, replay next cycle
//   mean_of_block      block mean, zero-extended to 2*DATA_WIDTH
//   variance_of_block  block variance
//   data_out           replayed pixel (0 outside the stream window)
//   frame_done         one-cycle pulse after the last block of a frame
//   dbg_state          replay FSM state (IDLE=0, ANNOUNCE=1, STREAM=2, FLUSH=3)
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid && pix_ready.
//   - pix_ready depends only on internal state, never on pix_valid.
//   - The producer holds pix_in stable while pix_valid is high and the pixel
//     has not yet transferred.
// -----------------------------------------------------------------------------
module wiener_block_feeder #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [31:0]             blocks_per_frame,
  output logic                    stats_ready,
  output logic [2*DATA_WIDTH-1:0] mean_of_block,
  output logic [2*DATA_WIDTH-1:0] variance_of_block,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    frame_done,
  output logic [1:0]              dbg_state
);

  localparam int DW   = DATA_WIDTH;
  localparam int TS   = TOTAL_SAMPLES;
  localparam int L    = $clog2(TS);
  localparam int SUMW = DW + L;
  localparam int SQW  = 2 * DW + L;
  localparam int OW   = 2 * DW;
  localparam logic [L-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ANNOUNCE = 2'd1,
    S_STREAM   = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t state, state_next;

  // Buffer and per-bank bookkeeping
  logic [DW-1:0]   mem [2][TS];
  logic [1:0]      full;
  logic [1:0]      stats_valid;
  logic [OW-1:0]   mean_reg [2];
  logic [OW-1:0]   var_reg  [2];

  // Ingest side
  logic            wr_bank;
  logic [L-1:0]    wr_ptr;
  logic [SUMW-1:0] sum_acc;
  logic [SQW-1:0]  sumsq_acc;
  logic            calc_pending;
  logic            calc_bank;
  logic            xfer;
  logic [SQW-1:0]  pix_sq;

  // Replay side
  logic            rd_bank;
  logic [L-1:0]    stream_cnt;
  logic [1:0]      flush_cnt;
  logic [31:0]     blk_cnt;
  logic [31:0]     bpf_lat;

  // FSM strobes
  logic            enter_announce;
  logic            ann_bank;
  logic            free_now;
  logic [1:0]      bank_ready;

  // Stats datapath
  logic [SUMW-1:0] mean_full;
  logic [DW-1:0]   mean_c;
  logic [SQW-1:0]  mean_ext;
  logic [SQW-1:0]  mean_sq;
  logic [SQW-1:0]  sq_mean;
  logic [SQW-1:0]  var_full;
  logic [OW-1:0]   var_c;

  assign bank_ready = full & stats_valid;

  // The bank being freed this cycle can accept its first new pixel at the
  // same edge, so a back-to-back producer loses no cycle at the hand-over.
  assign pix_ready  = !full[wr_bank] || (free_now && (wr_bank == rd_bank));
  assign xfer       = pix_valid && pix_ready;
  assign pix_sq     = SQW'(pix_in) * SQW'(pix_in);
  assign dbg_state  = state;

  // ---------------------------------------------------------------------------
  // Block statistics, evaluated from the accumulators in the cycle after a
  // bank fills. The accumulators may already be restarting for the next block
  // at the edge that registers these results. That is safe because the
  // registered value is taken from the pre-edge sums.
  // ---------------------------------------------------------------------------
  always_comb begin
    mean_full = '0;
    mean_c    = '0;
    mean_ext  = '0;
    mean_sq   = '0;
    sq_mean   = '0;
    var_full  = '0;
    var_c     = '0;
`ifdef MEAN_ROUND_EN
    mean_full = (sum_acc + SUMW'(TS / 2)) >> L;
`else
    mean_full = sum_acc >> L;
`endif
    // The mean of DW-bit pixels always fits DW bits. The saturation only
    // keeps the narrowing explicit.
    mean_c   = (|mean_full[SUMW-1:DW]) ? '1 : mean_full[DW-1:0];
    mean_ext = SQW'(mean_c);
    mean_sq  = mean_ext * mean_ext;
    sq_mean  = sumsq_acc >> L;
`ifdef MEAN_ROUND_EN
    // A rounded-up mean can push mean^2 above E[x^2].
    var_full = (mean_sq > sq_mean) ? '0 : (sq_mean - mean_sq);
`else
    var_full = sq_mean - mean_sq;
`endif
    var_c = (|var_full[SQW-1:OW]) ? '1 : var_full[OW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Replay FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Replay FSM: next state and strobes.
  // FLUSH exits straight into ANNOUNCE when the other bank is ready. This lets
  // back-to-back blocks announce every TS+4 cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    stats_ready    = 1'b0;
    enter_announce = 1'b0;
    ann_bank       = rd_bank;
    free_now       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bank_ready[rd_bank]) begin
          state_next     = S_ANNOUNCE;
          enter_announce = 1'b1;
          ann_bank       = rd_bank;
        end
      end
      S_ANNOUNCE: begin
        stats_ready = 1'b1;
        state_next  = S_STREAM;
      end
      S_STREAM: begin
        if (stream_cnt == LAST_IDX) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 2'd2) begin
          free_now = 1'b1;
          if (bank_ready[~rd_bank]) begin
            state_next     = S_ANNOUNCE;
            enter_announce = 1'b1;
            ann_bank       = ~rd_bank;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel storage (no reset: contents are only read after being written)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_bank][wr_ptr] <= pix_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Ingest, stats registers, replay datapath and frame counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full              <= '0;
      stats_valid       <= '0;
      mean_reg[0]       <= '0;
      mean_reg[1]       <= '0;
      var_reg[0]        <= '0;
      var_reg[1]        <= '0;
      wr_bank           <= 1'b0;
      wr_ptr            <= '0;
      sum_acc           <= '0;
      sumsq_acc         <= '0;
      calc_pending      <= 1'b0;
      calc_bank         <= 1'b0;
      rd_bank           <= 1'b0;
      stream_cnt        <= '0;
      flush_cnt         <= '0;
      blk_cnt           <= '0;
      bpf_lat           <= 32'd1;
      mean_of_block     <= '0;
      variance_of_block <= '0;
      data_out          <= '0;
      frame_done        <= 1'b0;
    end else begin
      calc_pending <= 1'b0;
      frame_done   <= 1'b0;
      data_out     <= '0;

      // Freeing the replayed bank: it is always the read bank, never the
      // one completing a fill in the same cycle.
      if (free_now) begin
        full[rd_bank]        <= 1'b0;
        stats_valid[rd_bank] <= 1'b0;
        rd_bank              <= ~rd_bank;
        if (blk_cnt == bpf_lat - 32'd1) begin
          frame_done <= 1'b1;
          blk_cnt    <= '0;
        end else begin
          blk_cnt <= blk_cnt + 32'd1;
        end
      end

      if (xfer) begin
        wr_ptr <= wr_ptr + L'(1);
        if (wr_ptr == '0) begin
          sum_acc   <= SUMW'(pix_in);
          sumsq_acc <= pix_sq;
        end else begin
          sum_acc   <= sum_acc + SUMW'(pix_in);
          sumsq_acc <= sumsq_acc + pix_sq;
        end
        if (wr_ptr == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          calc_pending  <= 1'b1;
          calc_bank     <= wr_bank;
        end
      end

      if (calc_pending) begin
        mean_reg[calc_bank]    <= {{DW{1'b0}}, mean_c};
        var_reg[calc_bank]     <= var_c;
        stats_valid[calc_bank] <= 1'b1;
      end

      if (enter_announce) begin
        mean_of_block     <= mean_reg[ann_bank];
        variance_of_block <= var_reg[ann_bank];
        if (blk_cnt == '0) begin
          bpf_lat <= (blocks_per_frame == '0) ? 32'd1 : blocks_per_frame;
        end
      end

      case (state)
        S_ANNOUNCE: begin
          data_out   <= mem[rd_bank][0];
          stream_cnt <= '0;
        end
        S_STREAM: begin
          if (stream_cnt != LAST_IDX) begin
            data_out   <= mem[rd_bank][stream_cnt + L'(1)];
            stream_cnt <= stream_cnt + L'(1);
          end else begin
            flush_cnt <= '0;
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wiener_block_feeder.sv
// -----------------------------------------------------------------------------
// tb_wiener_block_feeder
//
// Directed bench for wiener_block_feeder (DATA_WIDTH=8, TOTAL_SAMPLES=64).
//
// Stimulus:
//   - A table of single-block vectors, each with hand-computed mean/variance.
//   - Hand-written sequences for:
//     - back-to-back blocks
//     - frame counting
//     - reset during replay
//
// The monitor compares stats at every stats_ready and the replayed stream
// against an expected queue. It also checks the FLUSH zeros and the
// frame_done timing.
// -----------------------------------------------------------------------------
module tb_wiener_block_feeder;

  localparam int DW = 8;
  localparam int TS = 64;

`ifdef MEAN_ROUND_EN
  localparam int RAMP_MEAN = 32,  RAMP_VAR = 309;
  localparam int ALT_MEAN  = 128, ALT_VAR  = 16128;
  localparam int R64_MEAN  = 96,  R64_VAR  = 245;
  localparam int R128_MEAN = 160, R128_VAR = 181;
`else
  localparam int RAMP_MEAN = 31,  RAMP_VAR = 372;
  localparam int ALT_MEAN  = 127, ALT_VAR  = 16383;
  localparam int R64_MEAN  = 95,  R64_VAR  = 436;
  localparam int R128_MEAN = 159, R128_VAR = 500;
`endif

  // Clock and reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [31:0]   blocks_per_frame = '0;
  logic          stats_ready;
  logic [15:0]   mean_of_block;
  logic [15:0]   variance_of_block;
  logic [DW-1:0] data_out;
  logic          frame_done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  wiener_block_feeder #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(TS)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pix_in            (pix_in),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .blocks_per_frame  (blocks_per_frame),
    .stats_ready       (stats_ready),
    .mean_of_block     (mean_of_block),
    .variance_of_block (variance_of_block),
    .data_out          (data_out),
    .frame_done        (frame_done),
    .dbg_state         (dbg_state)
  );

  // Counters and scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_xfer_cyc = -1;
  int drop_at = -1;
  int mon_en = 0;
  int chk_spacing = 0;
  int stream_left = 0;
  int flush_left = 0;
  int last_stats_cyc = -1;
  int stats_cnt = 0;
  int fd_cnt = 0;
  int fd_log[$];

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_q[$];
  logic [15:0]   exp_mean_q[$];
  logic [15:0]   exp_var_q[$];

  typedef struct {
    int kind;
    int val;
    int exp_mean;
    int exp_var;
  } vec_t;

  vec_t vecs[6];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && pix_valid && pix_ready) last_xfer_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (mon_en != 0) begin
      if (stream_left > 0) begin
        if (exp_q.size() == 0) begin
          fail_now("replay_underflow");
        end else begin
          e = exp_q.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, e});
        end
        stream_left--;
        if (stream_left == 0) flush_left = 3;
      end else if (flush_left > 0) begin
        check("flush_zero", {24'd0, data_out}, 32'd0);
        flush_left--;
      end

      if (frame_done) begin
        fd_cnt++;
        fd_log.push_back(stats_cnt);
        check("frame_done_timing", cyc - last_stats_cyc, 68);
      end

      if (stats_ready) begin
        if (exp_mean_q.size() == 0) begin
          fail_now("unexpected_stats_ready");
        end else begin
          check("mean", {16'd0, mean_of_block}, {16'd0, exp_mean_q.pop_front()});
          check("variance", {16'd0, variance_of_block}, {16'd0, exp_var_q.pop_front()});
        end
        if (chk_spacing != 0 && last_stats_cyc >= 0)
          check("stats_spacing", cyc - last_stats_cyc, 68);
        last_stats_cyc = cyc;
        stats_cnt++;
        stream_left = TS;
      end
    end
  end

  function automatic logic [DW-1:0] pix_of(input int kind, input int val, input int i);
    case (kind)
      0:       return DW'(val);
      1:       return DW'(i + val);
      2:       return (i % 2 == 1) ? 8'd255 : 8'd0;
      default: return (i < 32) ? 8'd0 : 8'd200;
    endcase
  endfunction

  // Driver: sends everything in tx_q with pix_valid held high
  task automatic send_tx(input int bound);
    int sent;
    int waited;
    logic [DW-1:0] p;
    sent = 0;
    waited = 0;
    drop_at = -1;
    while (tx_q.size() > 0) begin
      @(negedge clk);
      pix_in = tx_q[0];
      pix_valid = 1'b1;
      #1;
      if (pix_ready) begin
        p = tx_q.pop_front();
        sent++;
        waited = 0;
      end else begin
        if (drop_at < 0) drop_at = sent;
        waited++;
        if (waited > bound) begin
          fail_now("ready_timeout");
          tx_q.delete();
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_in = '0;
  endtask

  task automatic queue_block(input int kind, input int val, input int em, input int ev);
    logic [DW-1:0] p;
    for (int i = 0; i < TS; i++) begin
      p = pix_of(kind, val, i);
      tx_q.push_back(p);
      exp_q.push_back(p);
    end
    exp_mean_q.push_back(16'(em));
    exp_var_q.push_back(16'(ev));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_mean_q.size() != 0 || stream_left != 0 || flush_left != 0)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_stats(output int found);
    int n;
    n = 0;
    while (!stats_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    found = stats_ready ? 1 : 0;
  endtask

  task automatic run_vec(input vec_t v);
    int found;
    queue_block(v.kind, v.val, v.exp_mean, v.exp_var);
    send_tx(200);
    wait_stats(found);
    if (found == 0) fail_now("stats_timeout");
    else check("stats_latency", cyc - last_xfer_cyc, 2);
    wait_idle();
    check("mean_hold_idle", {16'd0, mean_of_block}, v.exp_mean);
    check("data_out_idle", {24'd0, data_out}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_ready"}, {31'd0, pix_ready}, 32'd1);
    check({tag, "_stats_ready"}, {31'd0, stats_ready}, 32'd0);
    check({tag, "_mean"}, {16'd0, mean_of_block}, 32'd0);
    check({tag, "_var"}, {16'd0, variance_of_block}, 32'd0);
    check({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int found;

    vecs[0] = '{kind: 0, val: 100, exp_mean: 100,       exp_var: 0};
    vecs[1] = '{kind: 1, val: 0,   exp_mean: RAMP_MEAN, exp_var: RAMP_VAR};
    vecs[2] = '{kind: 2, val: 0,   exp_mean: ALT_MEAN,  exp_var: ALT_VAR};
    vecs[3] = '{kind: 3, val: 0,   exp_mean: 100,       exp_var: 10000};
    vecs[4] = '{kind: 0, val: 255, exp_mean: 255,       exp_var: 0};
    vecs[5] = '{kind: 0, val: 0,   exp_mean: 0,         exp_var: 0};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // Table: single blocks from idle; blocks_per_frame=0 means one block per frame
    blocks_per_frame = 32'd0;
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("frame_done_bpf0", fd_cnt, 6);

    // Three blocks back to back with pix_valid held high
    chk_spacing = 1;
    last_stats_cyc = -1;
    queue_block(1, 0,   RAMP_MEAN, RAMP_VAR);
    queue_block(1, 64,  R64_MEAN,  R64_VAR);
    queue_block(1, 128, R128_MEAN, R128_VAR);
    send_tx(200);
    check("ready_drop_point", drop_at, 128);
    wait_idle();
    chk_spacing = 0;

    // Frame of two blocks, four blocks sent
    blocks_per_frame = 32'd2;
    fd_cnt = 0;
    fd_log.delete();
    stats_cnt = 0;
    queue_block(0, 10, 10, 0);
    queue_block(0, 20, 20, 0);
    queue_block(0, 30, 30, 0);
    queue_block(0, 40, 40, 0);
    send_tx(200);
    wait_idle();
    check("frame_done_count", fd_cnt, 2);
    if (fd_log.size() == 2) begin
      check("frame_done_block_a", fd_log[0], 2);
      check("frame_done_block_b", fd_log[1], 4);
    end else begin
      fail_now("frame_done_log");
    end

    // Reset in the middle of a replay, with a partial block being ingested
    blocks_per_frame = 32'd1;
    queue_block(0, 50, 50, 0);
    send_tx(200);
    wait_stats(found);
    if (found == 0) fail_now("stats_timeout_pre_reset");
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'd7);
    send_tx(200);
    check("state_streaming", {30'd0, dbg_state}, 32'd2);
    mon_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_mean_q.delete();
    exp_var_q.delete();
    stream_left = 0;
    flush_left = 0;
    mon_en = 1;
    @(negedge clk);
    run_vec(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
